// File: rtl/count_seq_ctrl_if.sv
// Command channel for count_seq_ctrl.
// A command is a (start, end) range offered with a valid/ready handshake.
// Signals:
//   cmd_valid  command present (from the command source)
//   cmd_ready  controller can take a command this cycle
//   cmd_start  first value of the range
//   cmd_end    last value of the range, inclusive
// Modports:
//   master  command source
//   slave   controller
interface count_seq_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_start;
   logic [WIDTH-1:0] cmd_end;

   modport master (
      output cmd_valid,
      output cmd_start,
      output cmd_end,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_start,
      input  cmd_end,
      output cmd_ready
   );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencing controller for a bounded up-counter.
// Takes a (start, end) range command and steps out from start to end, one
// value per clock, with pause/abort and a completion pulse. With AUTO_RUN set
// it sweeps DEF_START..DEF_END once after every reset release.
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   cmd        command channel (slave side of count_seq_ctrl_if)
//   pause      hold the counter while high
//   abort      terminate the current run
//   out        counter value
//   out_valid  1-cycle strobe per new value of out
//   busy       high while running
//   done       1-cycle pulse when a run completes
//   err        1-cycle pulse when a command is rejected (end < start)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command or a pending auto-run
// RUN   | stepping out towards end_r
// DONE  | one-cycle completion state; may accept the next command
module count_seq_ctrl #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] DEF_START = WIDTH'(5),
   parameter logic [WIDTH-1:0] DEF_END   = WIDTH'(67),
   parameter bit               AUTO_RUN  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   count_seq_ctrl_if.slave  cmd,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             auto_pend;
   logic [WIDTH-1:0] end_r;

   logic [WIDTH-1:0] out_nxt;
   logic [WIDTH-1:0] end_nxt;
   logic             valid_nxt;
   logic             done_nxt;
   logic             err_nxt;

   logic             accept;
   logic             load;
   logic [WIDTH-1:0] ld_start;
   logic [WIDTH-1:0] ld_end;
   logic             ld_bad;
   logic             at_end;

   // A pending auto-run owns the load slot, so the external command is
   // refused on that cycle.
   assign cmd.cmd_ready = ((state == S_IDLE) || (state == S_DONE)) && !abort && !auto_pend;
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   assign load          = (state != S_RUN) && (auto_pend || accept);
   assign ld_start      = auto_pend ? DEF_START : cmd.cmd_start;
   assign ld_end        = auto_pend ? DEF_END   : cmd.cmd_end;
   assign ld_bad        = ld_end < ld_start;
   assign at_end        = (out == end_r);
   assign busy          = (state == S_RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         auto_pend <= AUTO_RUN;
         end_r     <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         // The flag is only ever armed in IDLE, where it is consumed by the
         // first edge out of reset.
         auto_pend <= 1'b0;
         end_r     <= end_nxt;
         out       <= out_nxt;
         out_valid <= valid_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (load && !ld_bad) state_nxt = S_RUN;
            else                 state_nxt = S_IDLE;
         end
         S_RUN: begin
            if (abort)       state_nxt = S_IDLE;
            else if (pause)  state_nxt = S_RUN;
            else if (at_end) state_nxt = S_DONE;
            else             state_nxt = S_RUN;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      out_nxt   = out;
      end_nxt   = end_r;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (load) begin
               if (ld_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  out_nxt   = ld_start;
                  end_nxt   = ld_end;
                  valid_nxt = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (abort || pause) begin
               out_nxt = out;
            end else if (at_end) begin
               done_nxt = 1'b1;
            end else begin
               // out < end_r here, so the increment cannot wrap.
               out_nxt   = out + WIDTH'(1);
               valid_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_count_seq_ctrl.sv
module tb_count_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pause;
   logic       abort;
   logic [7:0] out;
   logic       out_valid;
   logic       busy;
   logic       done;
   logic       err;

   int n_vec    = 0;
   int n_err    = 0;
   int busy_cyc = 0;

   count_seq_ctrl_if #(.WIDTH(8)) cmd_if ();

   count_seq_ctrl #(
      .WIDTH     (8),
      .DEF_START (8'd5),
      .DEF_END   (8'd67),
      .AUTO_RUN  (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd_if.slave),
      .pause     (pause),
      .abort     (abort),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      if (busy === 1'b1) busy_cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vals(input int lo, input int hi);
      for (int v = lo; v <= hi; v++) begin
         check("out", out, v);
         check("out_valid", out_valid, 1);
         if (v != hi) step();
      end
   endtask

   task automatic send(input logic [7:0] s, input logic [7:0] e);
      cmd_if.cmd_start = s;
      cmd_if.cmd_end   = e;
      cmd_if.cmd_valid = 1'b1;
   endtask

   initial begin
      int k;
      rst_n            = 1'b0;
      pause            = 1'b0;
      abort            = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_start = 8'd0;
      cmd_if.cmd_end   = 8'd0;
      step();
      step();

      // reset state
      check("rst_out", out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_ready_autopend", cmd_if.cmd_ready, 0);

      // auto-run sweep; a command offered on the release edge is ignored
      send(8'd1, 8'd2);
      rst_n = 1'b1;
      #1;
      check("auto_ready", cmd_if.cmd_ready, 0);
      step();
      cmd_if.cmd_valid = 1'b0;
      check("auto_busy", busy, 1);
      run_vals(5, 67);
      step();
      check("auto_done", done, 1);
      check("auto_done_valid", out_valid, 0);
      check("auto_done_out", out, 67);
      check("auto_done_busy", busy, 0);
      step();
      check("auto_done_clr", done, 0);
      check("auto_idle_busy", busy, 0);
      check("auto_idle_out", out, 67);
      check("auto_idle_ready", cmd_if.cmd_ready, 1);

      // command 10..12, then 20..20 accepted straight from DONE
      send(8'd10, 8'd12);
      #1;
      check("c1_ready", cmd_if.cmd_ready, 1);
      step();
      cmd_if.cmd_valid = 1'b0;
      for (int v = 10; v <= 12; v++) begin
         check("c1_out", out, v);
         check("c1_valid", out_valid, 1);
         check("c1_busy", busy, 1);
         step();
      end
      check("c1_done", done, 1);
      check("c1_done_busy", busy, 0);
      check("c1_done_valid", out_valid, 0);
      send(8'd20, 8'd20);
      #1;
      check("c2_ready_in_done", cmd_if.cmd_ready, 1);
      step();
      cmd_if.cmd_valid = 1'b0;
      check("c2_out", out, 20);
      check("c2_valid", out_valid, 1);
      check("c2_busy", busy, 1);
      step();
      check("c2_done", done, 1);
      check("c2_done_valid", out_valid, 0);
      check("c2_done_out", out, 20);
      step();
      check("c2_done_clr", done, 0);
      check("c2_idle_busy", busy, 0);

      // 0..9 with pause held for 3 cycles after value 4
      send(8'd0, 8'd9);
      step();
      cmd_if.cmd_valid = 1'b0;
      busy_cyc = 0;
      run_vals(0, 4);
      pause = 1'b1;
      repeat (3) begin
         step();
         check("p_hold_out", out, 4);
         check("p_hold_valid", out_valid, 0);
         check("p_hold_busy", busy, 1);
      end
      pause = 1'b0;
      step();
      run_vals(5, 9);
      step();
      check("p_done", done, 1);
      check("p_run_len", busy_cyc, 13);
      step();

      // 0..100 aborted at 30 while a command is offered
      send(8'd0, 8'd100);
      step();
      cmd_if.cmd_valid = 1'b0;
      run_vals(0, 30);
      abort = 1'b1;
      send(8'd1, 8'd2);
      #1;
      check("ab_ready", cmd_if.cmd_ready, 0);
      step();
      abort = 1'b0;
      #1;
      check("ab_busy", busy, 0);
      check("ab_out", out, 30);
      check("ab_valid", out_valid, 0);
      check("ab_no_done", done, 0);
      check("ab_ready_after", cmd_if.cmd_ready, 1);
      step();
      cmd_if.cmd_valid = 1'b0;
      run_vals(1, 2);
      step();
      check("ab2_done", done, 1);
      // abort in DONE blocks the accept
      abort = 1'b1;
      send(8'd7, 8'd8);
      #1;
      check("ab_done_ready", cmd_if.cmd_ready, 0);
      step();
      abort = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      check("ab_done_busy", busy, 0);
      check("ab_done_valid", out_valid, 0);
      check("ab_done_out", out, 2);

      // rejected command end < start
      send(8'd50, 8'd40);
      #1;
      check("e_ready", cmd_if.cmd_ready, 1);
      step();
      cmd_if.cmd_valid = 1'b0;
      check("e_err", err, 1);
      check("e_busy", busy, 0);
      check("e_valid", out_valid, 0);
      check("e_done", done, 0);
      check("e_out", out, 2);
      step();
      check("e_err_clr", err, 0);
      check("e_ready_after", cmd_if.cmd_ready, 1);
      check("e_busy_after", busy, 0);

      // reset mid-sweep at 33 restarts the auto-run from 5
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      run_vals(5, 33);
      rst_n = 1'b0;
      step();
      check("mr_out", out, 0);
      check("mr_valid", out_valid, 0);
      check("mr_busy", busy, 0);
      check("mr_done", done, 0);
      rst_n = 1'b1;
      step();
      check("mr_restart_out", out, 5);
      check("mr_restart_valid", out_valid, 1);
      check("mr_restart_busy", busy, 1);
      k = 0;
      while (done !== 1'b1 && k < 200) begin
         step();
         k++;
      end
      check("mr_done_seen", done, 1);
      check("mr_sweep_len", k, 63);
      check("mr_final_out", out, 67);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
- Controller that sequences a bounded up-counter datapath.
- Accepts a range command (start, end) over a valid/ready handshake and steps the counter from start to end, one value per clock.
- Supports pause, abort and a completion pulse.
- Optional auto-run after reset sweeps the default range 5..67, so the stimulus bench works without a command source.

Parameters:
- WIDTH, 8, width of counter value and command fields.
- DEF_START, 5, start value for auto-run.
- DEF_END, 67, end value for auto-run.
- AUTO_RUN, 1, 1 = run DEF_START..DEF_END once after every reset release; 0 = wait for a command.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command can be accepted.
- cmd_start  input  WIDTH  first value of the range.
- cmd_end  input  WIDTH  last value of the range, inclusive.
- pause  input  1  hold the counter while high.
- abort  input  1  terminate the current run.
- out  output  WIDTH  counter value.
- out_valid  output  1  1-cycle strobe per new value of out.
- busy  output  1  high while in RUN.
- done  output  1  1-cycle pulse when the run completes.
- err  output  1  1-cycle pulse when a command is rejected.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE.
  - out=0, out_valid=0, busy=0, done=0, err=0.
  - An internal flag arms auto-run when AUTO_RUN=1.
- Auto-run:
  - Applies on the first edge with rst_n=1 and the flag armed.
  - Acts as an accepted command with DEF_START/DEF_END; the flag then clears.
  - A simultaneous cmd_valid is not accepted; cmd_ready=0 on that cycle.
- States are IDLE, RUN and DONE. busy=1 only in RUN.
- cmd_ready is combinational:
  - High only when the state is IDLE or DONE, abort=0, and no auto-run is pending.
  - A command is accepted on a posedge when cmd_valid and cmd_ready are both high.
- On accept:
  - If cmd_end < cmd_start (unsigned): err<=1 for one cycle, state goes to IDLE, out is unchanged.
  - Otherwise: latch end_r<=cmd_end, out<=cmd_start, out_valid<=1, state goes to RUN.
- RUN, evaluated each posedge in priority order:
  1. abort=1: state goes to IDLE, out_valid<=0, out holds, no done pulse.
  2. pause=1: out holds, out_valid<=0.
  3. out==end_r: state goes to DONE, done<=1, out_valid<=0, out holds the end value.
  4. Otherwise: out<=out+1, out_valid<=1.
- DONE:
  - Lasts one cycle; done clears next edge.
  - A command may be accepted directly from DONE (back-to-back runs). Otherwise the state goes to IDLE.
- Latency and counts:
  - The first value appears on out the edge after accept.
  - A run of start..end gives exactly end-start+1 out_valid strobes when not paused.
  - Each pause cycle adds exactly one cycle.
  - done rises one cycle after the last strobe.
- start==end gives one strobe, then done on the next edge.
- No wrap-around: out only increments while out < end_r ≤ 2^WIDTH-1.
- pause and abort in IDLE or DONE have no effect. abort in DONE still blocks accept for that cycle.
- Reset mid-run gives reset values on the next edge. Auto-run, if enabled, restarts the sweep from DEF_START.
- out_valid, done and err are never high in the same cycle.

Test Plan:
- AUTO_RUN=1, release rst_n after 2 cycles, clk period 10 → out strobes 5,6,...,67 on consecutive cycles (63 strobes), done pulses once on the cycle after 67, then IDLE with out=67, cmd_ready=1.
- AUTO_RUN=0, command start=10 end=12 → out_valid strobes 10,11,12 on cycles 1–3 after accept, done on cycle 4, busy high for cycles 1–3; then command start=20 end=20 accepted from DONE → single strobe 20, done next cycle.
- Run 0..9 with pause held 3 cycles after value 4 → no strobes during pause, 5 follows after exactly 3 extra cycles, total run length 13 cycles, done after 9.
- Run 0..100, abort asserted after value 30 together with cmd_valid (start=1 end=2) → IDLE, no done, out stays 30, command not accepted that cycle; same command accepted next cycle → strobes 1,2.
- Command start=50 end=40 → err pulse one cycle, no strobes, state IDLE, cmd_ready=1 next cycle.
- Reset asserted for one cycle mid-run at value 33 (AUTO_RUN=1) → outputs zeroed next edge, sweep restarts at 5 after release.
